atm_txn_arbiter: RTL and testbench
==================================

// Module: atm_txn_arbiter
// PURPOSE
// - Shares one ATM core among N_TERM terminals. Round-robin grants one transaction at a time.
// - Sequences the core: park, run TXN_CYCLES, capture. Returns balance/success to the granted terminal.
// - Adds a per-account wrong-attempt lockout in front of the core.
// PARAMETERS
// N_TERM      4   number of requesting terminals
// TXN_CYCLES  4   cycles core_rst_n is held high per transaction (core latency)
// NUM_ACC     10  valid account numbers are 1..NUM_ACC
// LOCK_LIMIT  3   consecutive failures that lock an account
// PORTS
// clk           in   1        clock, rising edge
// rst           in   1        asynchronous, active-high reset
// req_valid     in   N_TERM   terminal i requests; held until req_ready[i]
// req_ready     out  N_TERM   one-cycle accept pulse, one-hot
// req_op        in   3*N_TERM op per terminal (3 balance, 4 withdraw, 5 deposit, 6 change PIN)
// req_acc       in   4*N_TERM account number per terminal
// req_pin       in   16*N_TERM PIN per terminal
// req_new_pin   in   16*N_TERM new PIN per terminal
// req_amount    in   32*N_TERM amount per terminal
// req_lang      in   N_TERM   language select per terminal
// rsp_valid     out  N_TERM   one-cycle response pulse, one-hot, to the granted terminal
// rsp_balance   out  32       captured balance, valid with rsp_valid
// rsp_success   out  1        captured success
// rsp_locked    out  1        1 = account locked, core not used
// unlock_valid  in   1        admin clear of one account's fail counter
// unlock_acc    in   4        account to unlock
// core_rst_n    out  1        core enable; 0 parks core in idle state 7
// core_op, core_acc, core_pin, core_new_pin, core_amount, core_lang  out  3/4/16/16/32/1  latched request
// core_balance  in   32       core balance output
// core_success  in   1        core success output
// BEHAVIOUR
// - Reset: all outputs are 0, FSM is IDLE, RR pointer is 0, and all fail counters are 0.
// - FSM: IDLE -> PARK -> RUN -> CAPT -> RESP -> IDLE.
//   - An immediate reject goes IDLE -> RESP.
// - IDLE: if any req_valid, pick the first set bit at or after the RR pointer, wrapping.
//   - Pulse req_ready[g]. Latch all fields of terminal g into core_* registers. Set the pointer to g+1 mod N_TERM.
// - Immediate reject from IDLE to RESP, core untouched:
//   - acc 0 or acc > NUM_ACC, or op not in 3..6: success=0, locked=0.
//   - Account locked (fail count == LOCK_LIMIT): success=0, locked=1, balance=0.
// - PARK: 1 cycle with core_rst_n=0.
// - RUN: core_rst_n=1 for exactly TXN_CYCLES cycles, using a down-counter.
// - CAPT: core_rst_n=0. Sample core_balance and core_success into rsp regs.
//   - success=1 clears that account's fail counter.
//   - success=0 increments it, saturating at LOCK_LIMIT.
// - RESP: rsp_valid[g]=1 for 1 cycle. rsp_* stay valid until the next RESP.
// - Latency, normal path: rsp_valid is asserted TXN_CYCLES+3 cycles after the req_ready edge (7 at defaults).
// - Latency, reject path: rsp_valid is asserted 1 cycle after the req_ready edge.
// - Requests arriving while busy wait; req_valid dropped before grant is legal and is ignored.
// - Only one transaction is in flight; no pipelining.
// - Unlock clears the counter in the cycle it is asserted.
//   - If it coincides with a CAPT increment on the same account, unlock wins (counter=0).
// - Mid-transaction rst: aborts immediately to the reset state. No rsp_valid. core_rst_n=0 asynchronously.
// - Counters are stored for accounts 1..NUM_ACC only.
// STRUCTURE
// - atm_pkg: op codes (OP_BAL=3, OP_WD=4, OP_DEP=5, OP_PIN=6), FSM state localparams, width constants.
// - Sub-module atm_rr_pick: combinational N_TERM round-robin picker (req, ptr -> one-hot grant, any).
// - Top: FSM, cycle counter, request latch, fail-counter array, response regs.
// TESTING
// - Core model: acc1/pin1234/bal1000, acc2/pin2345/bal2000.
// - T0 req acc1 op3 pin1234 -> req_ready[0] at cycle 0, rsp_valid[0] at cycle 7, balance=1000, success=1.
// - All 4 terminals valid at once (acc1 op3) -> grants in order 0,1,2,3. Then T0 re-request -> grant 0 again.
// - T1 acc2 pin2346, three times -> success=0 x3. Fourth attempt with pin2345 -> locked=1, rsp at +1 cycle.
// - unlock acc2, then T1 acc2 pin2345 op5 amount 1000 -> success=1, balance=3000.
// - T2 acc 0 and T2 acc 11 -> success=0, locked=0, core_rst_n stays 0.
// - rst pulse during RUN -> no rsp_valid, all counters 0. The next request is served normally.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared constants and types for the ATM transaction arbiter.
package atm_pkg;

   localparam int OP_W  = 3;
   localparam int ACC_W = 4;
   localparam int PIN_W = 16;
   localparam int AMT_W = 32;

   // Core operation codes
   localparam logic [OP_W-1:0] OP_BAL = 3'd3;
   localparam logic [OP_W-1:0] OP_WD  = 3'd4;
   localparam logic [OP_W-1:0] OP_DEP = 3'd5;
   localparam logic [OP_W-1:0] OP_PIN = 3'd6;

   // Arbiter FSM states
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_PARK = 3'd1;
   localparam logic [2:0] ST_RUN  = 3'd2;
   localparam logic [2:0] ST_CAPT = 3'd3;
   localparam logic [2:0] ST_RESP = 3'd4;

   // One terminal's request, in the order the core port fields are listed
   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [ACC_W-1:0] acc;
      logic [PIN_W-1:0] pin;
      logic [PIN_W-1:0] new_pin;
      logic [AMT_W-1:0] amount;
      logic             lang;
   } req_t;

   function automatic logic op_is_valid(input logic [OP_W-1:0] op);
      return (op >= OP_BAL) && (op <= OP_PIN);
   endfunction

endpackage

// File: rtl/atm_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module atm_rr_pick #(
   parameter int N_TERM = 4,
   parameter int PTR_W  = 2
) (
   input  logic [N_TERM-1:0] req,
   input  logic [PTR_W-1:0]  ptr,
   output logic [N_TERM-1:0] grant,
   output logic [PTR_W-1:0]  grant_idx,
   output logic              any
);

   int               pos;
   logic [PTR_W-1:0] cand;

   // Scan positions ptr, ptr+1, ... and keep the first active request
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      pos       = 0;
      cand      = '0;
      for (int i = 0; i < N_TERM; i++) begin
         pos  = (int'(ptr) + i) % N_TERM;
         cand = pos[PTR_W-1:0];
         if (!any && req[cand]) begin
            grant[cand] = 1'b1;
            grant_idx   = cand;
            any         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/atm_txn_arbiter.sv
// Shares one ATM core among N_TERM terminals, one transaction at a time,
// with a per-account wrong-attempt lockout in front of the core.
module atm_txn_arbiter
   import atm_pkg::*;
#(
   parameter int N_TERM     = 4,
   parameter int TXN_CYCLES = 4,
   parameter int NUM_ACC    = 10,
   parameter int LOCK_LIMIT = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_TERM-1:0]       req_valid,
   output logic [N_TERM-1:0]       req_ready,
   input  logic [OP_W*N_TERM-1:0]  req_op,
   input  logic [ACC_W*N_TERM-1:0] req_acc,
   input  logic [PIN_W*N_TERM-1:0] req_pin,
   input  logic [PIN_W*N_TERM-1:0] req_new_pin,
   input  logic [AMT_W*N_TERM-1:0] req_amount,
   input  logic [N_TERM-1:0]       req_lang,
   output logic [N_TERM-1:0]       rsp_valid,
   output logic [AMT_W-1:0]        rsp_balance,
   output logic                    rsp_success,
   output logic                    rsp_locked,
   input  logic                    unlock_valid,
   input  logic [ACC_W-1:0]        unlock_acc,
   output logic                    core_rst_n,
   output logic [OP_W-1:0]         core_op,
   output logic [ACC_W-1:0]        core_acc,
   output logic [PIN_W-1:0]        core_pin,
   output logic [PIN_W-1:0]        core_new_pin,
   output logic [AMT_W-1:0]        core_amount,
   output logic                    core_lang,
   input  logic [AMT_W-1:0]        core_balance,
   input  logic                    core_success
);

   localparam int PTR_W = (N_TERM > 1) ? $clog2(N_TERM) : 1;
   localparam int CNT_W = $clog2(LOCK_LIMIT + 1);
   localparam int RUN_W = (TXN_CYCLES > 1) ? $clog2(TXN_CYCLES) : 1;

   logic [2:0]        state_reg, state_next;
   logic [PTR_W-1:0]  ptr_reg;
   logic [RUN_W-1:0]  run_cnt_reg;
   req_t              core_req_reg;
   logic [N_TERM-1:0] owner_reg;
   logic [AMT_W-1:0]  rsp_balance_reg;
   logic              rsp_success_reg;
   logic              rsp_locked_reg;

   req_t              req_arr [N_TERM];
   logic [N_TERM-1:0] grant;
   logic [PTR_W-1:0]  grant_idx;
   logic              grant_any;
   req_t              sel;
   logic              acc_ok;
   logic              op_ok;
   logic              sel_locked;
   logic [NUM_ACC:0]  locked_vec;
   logic [PTR_W-1:0]  ptr_after;

   // Slice the flat per-terminal buses into request records
   for (genvar gi = 0; gi < N_TERM; gi++) begin : g_unpack
      assign req_arr[gi] = {req_op[gi*OP_W +: OP_W],
                            req_acc[gi*ACC_W +: ACC_W],
                            req_pin[gi*PIN_W +: PIN_W],
                            req_new_pin[gi*PIN_W +: PIN_W],
                            req_amount[gi*AMT_W +: AMT_W],
                            req_lang[gi]};
   end

   atm_rr_pick #(
      .N_TERM (N_TERM),
      .PTR_W  (PTR_W)
   ) u_pick (
      .req       (req_valid),
      .ptr       (ptr_reg),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (grant_any)
   );

   assign sel        = req_arr[grant_idx];
   assign acc_ok     = (sel.acc != '0) && (sel.acc <= ACC_W'(NUM_ACC));
   assign op_ok      = op_is_valid(sel.op);
   assign sel_locked = acc_ok && locked_vec[sel.acc];
   assign ptr_after  = (grant_idx == PTR_W'(N_TERM - 1)) ? '0 : grant_idx + 1'b1;

   // Account 0 does not exist and is never locked
   assign locked_vec[0] = 1'b0;

   // One saturating fail counter per valid account; unlock beats a capture update
   for (genvar gi = 1; gi <= NUM_ACC; gi++) begin : g_acc
      logic [CNT_W-1:0] fail_cnt_reg;

      // Admin unlock clears; a capture clears on success, counts up on failure
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            fail_cnt_reg <= '0;
         end else if (unlock_valid && (unlock_acc == ACC_W'(gi))) begin
            fail_cnt_reg <= '0;
         end else if ((state_reg == ST_CAPT) && (core_req_reg.acc == ACC_W'(gi))) begin
            if (core_success) begin
               fail_cnt_reg <= '0;
            end else if (fail_cnt_reg != CNT_W'(LOCK_LIMIT)) begin
               fail_cnt_reg <= fail_cnt_reg + 1'b1;
            end
         end
      end

      assign locked_vec[gi] = (fail_cnt_reg == CNT_W'(LOCK_LIMIT));
   end

   // Transaction sequencing; rejected requests skip the core entirely
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (grant_any) state_next = (acc_ok && op_ok && !sel_locked) ? ST_PARK : ST_RESP;
         ST_PARK: state_next = ST_RUN;
         ST_RUN:  if (run_cnt_reg == '0) state_next = ST_CAPT;
         ST_CAPT: state_next = ST_RESP;
         ST_RESP: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // State, grant pointer, request latch, run counter and response registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         ptr_reg         <= '0;
         run_cnt_reg     <= '0;
         core_req_reg    <= '0;
         owner_reg       <= '0;
         rsp_balance_reg <= '0;
         rsp_success_reg <= 1'b0;
         rsp_locked_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            ST_IDLE: begin
               if (grant_any) begin
                  ptr_reg      <= ptr_after;
                  core_req_reg <= sel;
                  owner_reg    <= grant;
                  if (!(acc_ok && op_ok)) begin
                     rsp_balance_reg <= '0;
                     rsp_success_reg <= 1'b0;
                     rsp_locked_reg  <= 1'b0;
                  end else if (sel_locked) begin
                     rsp_balance_reg <= '0;
                     rsp_success_reg <= 1'b0;
                     rsp_locked_reg  <= 1'b1;
                  end
               end
            end
            ST_PARK: run_cnt_reg <= RUN_W'(TXN_CYCLES - 1);
            ST_RUN: begin
               if (run_cnt_reg != '0) run_cnt_reg <= run_cnt_reg - 1'b1;
            end
            ST_CAPT: begin
               rsp_balance_reg <= core_balance;
               rsp_success_reg <= core_success;
               rsp_locked_reg  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Accept is a same-cycle decode of the pick so the latency counts from it
   assign req_ready    = (state_reg == ST_IDLE && !rst) ? grant : '0;
   assign rsp_valid    = (state_reg == ST_RESP) ? owner_reg : '0;
   assign core_rst_n   = (state_reg == ST_RUN);
   assign rsp_balance  = rsp_balance_reg;
   assign rsp_success  = rsp_success_reg;
   assign rsp_locked   = rsp_locked_reg;
   assign core_op      = core_req_reg.op;
   assign core_acc     = core_req_reg.acc;
   assign core_pin     = core_req_reg.pin;
   assign core_new_pin = core_req_reg.new_pin;
   assign core_amount  = core_req_reg.amount;
   assign core_lang    = core_req_reg.lang;

endmodule

// File: tb/tb_atm_txn_arbiter.sv
// Scoreboard bench for atm_txn_arbiter with a small behavioural ATM core.
module tb_atm_txn_arbiter;

   localparam int TXN_CYCLES = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [11:0]  req_op;
   logic [15:0]  req_acc;
   logic [63:0]  req_pin;
   logic [63:0]  req_new_pin;
   logic [127:0] req_amount;
   logic [3:0]   req_lang;
   logic [3:0]   rsp_valid;
   logic [31:0]  rsp_balance;
   logic         rsp_success;
   logic         rsp_locked;
   logic         unlock_valid;
   logic [3:0]   unlock_acc;
   logic         core_rst_n;
   logic [2:0]   core_op;
   logic [3:0]   core_acc;
   logic [15:0]  core_pin;
   logic [15:0]  core_new_pin;
   logic [31:0]  core_amount;
   logic         core_lang;
   logic [31:0]  core_balance;
   logic         core_success;

   atm_txn_arbiter dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_acc(req_acc),
      .req_pin(req_pin), .req_new_pin(req_new_pin), .req_amount(req_amount), .req_lang(req_lang),
      .rsp_valid(rsp_valid), .rsp_balance(rsp_balance), .rsp_success(rsp_success), .rsp_locked(rsp_locked),
      .unlock_valid(unlock_valid), .unlock_acc(unlock_acc),
      .core_rst_n(core_rst_n), .core_op(core_op), .core_acc(core_acc), .core_pin(core_pin),
      .core_new_pin(core_new_pin), .core_amount(core_amount), .core_lang(core_lang),
      .core_balance(core_balance), .core_success(core_success)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          term;
      logic [31:0] bal;
      logic        suc;
      logic        lck;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_miss = 0;
   int   cyc = 0;
   int   run_edges = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Behavioural core: result appears after TXN_CYCLES enabled cycles
   initial begin
      logic [31:0] m_bal [16];
      logic [15:0] m_pin [16];
      int          m_cnt;
      int          a;
      for (int k = 0; k < 16; k++) begin
         m_bal[k] = 0;
         m_pin[k] = 16'hFFFF;
      end
      m_bal[1] = 1000; m_pin[1] = 16'd1234;
      m_bal[2] = 2000; m_pin[2] = 16'd2345;
      m_cnt = 0;
      core_balance = 0;
      core_success = 1'b0;
      forever begin
         @(negedge clk);
         if (!core_rst_n) begin
            m_cnt = 0;
         end else begin
            m_cnt++;
            if (m_cnt == 1) begin
               core_balance = 0;
               core_success = 1'b0;
            end
            if (m_cnt == TXN_CYCLES) begin
               a = int'(core_acc);
               if (!((a == 1 || a == 2) && core_pin == m_pin[a])) begin
                  core_balance = 0;
                  core_success = 1'b0;
               end else begin
                  case (core_op)
                     3'd3: core_success = 1'b1;
                     3'd4: begin
                        core_success = (core_amount <= m_bal[a]);
                        if (core_success) m_bal[a] = m_bal[a] - core_amount;
                     end
                     3'd5: begin
                        m_bal[a] = m_bal[a] + core_amount;
                        core_success = 1'b1;
                     end
                     3'd6: begin
                        m_pin[a] = core_new_pin;
                        core_success = 1'b1;
                     end
                     default: core_success = 1'b0;
                  endcase
                  core_balance = m_bal[a];
               end
            end
         end
      end
   end

   // Monitor: track grants, pop the scoreboard on every response pulse
   initial begin
      logic [3:0] last_grant;
      int         grant_cyc;
      exp_t       e;
      last_grant = '0;
      grant_cyc = 0;
      forever begin
         @(negedge clk);
         if (core_rst_n) run_edges++;
         if (req_ready != '0) begin
            last_grant = req_ready;
            grant_cyc = cyc;
         end
         if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL unexpected_rsp: rsp_valid=%b, nothing outstanding", rsp_valid);
            end else begin
               e = sb.pop_front();
               $display("rsp term=%0d bal=%0d suc=%0b lck=%0b lat=%0d",
                        e.term, rsp_balance, rsp_success, rsp_locked, cyc - grant_cyc);
               chk("rsp_term", 32'(rsp_valid), 32'(1) << e.term);
               chk("grant_term", 32'(last_grant), 32'(1) << e.term);
               chk("rsp_balance", rsp_balance, e.bal);
               chk("rsp_success", 32'(rsp_success), 32'(e.suc));
               chk("rsp_locked", 32'(rsp_locked), 32'(e.lck));
               chk("rsp_latency", 32'(cyc - grant_cyc), 32'(e.lat));
            end
         end
      end
   end

   task automatic set_req(input int t, input logic [2:0] op, input logic [3:0] acc,
                          input logic [15:0] pin, input logic [15:0] np, input logic [31:0] amt);
      req_op[t*3 +: 3]       = op;
      req_acc[t*4 +: 4]      = acc;
      req_pin[t*16 +: 16]    = pin;
      req_new_pin[t*16 +: 16] = np;
      req_amount[t*32 +: 32] = amt;
      req_lang[t]            = t[0];
      req_valid[t]           = 1'b1;
   endtask

   task automatic expect_rsp(input int t, input logic [31:0] bal, input logic suc,
                             input logic lck, input int lat);
      exp_t e;
      e.term = t; e.bal = bal; e.suc = suc; e.lck = lck; e.lat = lat;
      sb.push_back(e);
   endtask

   task automatic await_grant(input int t);
      logic got = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (req_ready[t]) begin
            got = 1'b1;
            break;
         end
      end
      chk($sformatf("grant_t%0d", t), 32'(got), 32'd1);
      @(posedge clk);
      #1 req_valid[t] = 1'b0;
   endtask

   task automatic txn(input int t, input logic [2:0] op, input logic [3:0] acc,
                      input logic [15:0] pin, input logic [15:0] np, input logic [31:0] amt,
                      input logic [31:0] bal, input logic suc, input logic lck, input int lat);
      expect_rsp(t, bal, suc, lck, lat);
      set_req(t, op, acc, pin, np, amt);
      await_grant(t);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (sb.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("drain", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_core(input logic level);
      logic got = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (core_rst_n == level) begin
            got = 1'b1;
            break;
         end
      end
      chk("core_rst_n_wait", 32'(got), 32'd1);
   endtask

   task automatic do_unlock(input logic [3:0] acc);
      unlock_valid = 1'b1;
      unlock_acc = acc;
      @(posedge clk);
      #1 unlock_valid = 1'b0;
   endtask

   initial begin
      int r0;
      req_valid = '0; req_op = '0; req_acc = '0; req_pin = '0; req_new_pin = '0;
      req_amount = '0; req_lang = '0; unlock_valid = 1'b0; unlock_acc = '0;
      repeat (3) @(negedge clk);
      chk("reset_req_ready", 32'(req_ready), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_core_rst_n", 32'(core_rst_n), 32'd0);
      chk("reset_rsp_balance", rsp_balance, 32'd0);
      chk("reset_rsp_flags", {30'd0, rsp_success, rsp_locked}, 32'd0);
      chk("reset_core_amount", core_amount, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // All four terminals at once: served 0,1,2,3
      for (int t = 0; t < 4; t++) begin
         expect_rsp(t, 1000, 1'b1, 1'b0, 7);
         set_req(t, 3'd3, 4'd1, 16'd1234, 16'd0, 32'd0);
      end
      fork
         await_grant(0);
         await_grant(1);
         await_grant(2);
         await_grant(3);
      join
      // Pointer has wrapped back to 0
      txn(0, 3'd3, 4'd1, 16'd1234, 16'd0, 0, 1000, 1'b1, 1'b0, 7);

      // Three wrong PINs lock account 2; the correct PIN is then refused at once
      for (int i = 0; i < 3; i++) txn(1, 3'd3, 4'd2, 16'd2346, 16'd0, 0, 0, 1'b0, 1'b0, 7);
      txn(1, 3'd3, 4'd2, 16'd2345, 16'd0, 0, 0, 1'b0, 1'b1, 1);
      wait_idle();
      do_unlock(4'd2);
      txn(1, 3'd5, 4'd2, 16'd2345, 16'd0, 1000, 3000, 1'b1, 1'b0, 7);

      // Bad account numbers and a bad op never start the core
      wait_idle();
      r0 = run_edges;
      txn(2, 3'd3, 4'd0, 16'd1234, 16'd0, 0, 0, 1'b0, 1'b0, 1);
      txn(2, 3'd3, 4'd11, 16'd1234, 16'd0, 0, 0, 1'b0, 1'b0, 1);
      txn(2, 3'd7, 4'd1, 16'd1234, 16'd0, 0, 0, 1'b0, 1'b0, 1);
      wait_idle();
      chk("reject_core_idle", 32'(run_edges), 32'(r0));

      // Unlock landing in the same cycle as the third failure's capture wins
      for (int i = 0; i < 2; i++) txn(1, 3'd3, 4'd2, 16'd1111, 16'd0, 0, 0, 1'b0, 1'b0, 7);
      expect_rsp(1, 0, 1'b0, 1'b0, 7);
      set_req(1, 3'd3, 4'd2, 16'd1111, 16'd0, 0);
      await_grant(1);
      wait_core(1'b1);
      wait_core(1'b0);
      unlock_valid = 1'b1;
      unlock_acc = 4'd2;
      @(posedge clk);
      #1 unlock_valid = 1'b0;
      wait_idle();
      txn(1, 3'd3, 4'd2, 16'd2345, 16'd0, 0, 3000, 1'b1, 1'b0, 7);

      // Lock account 2 again, then abort a transaction with reset
      for (int i = 0; i < 3; i++) txn(1, 3'd3, 4'd2, 16'd1111, 16'd0, 0, 0, 1'b0, 1'b0, 7);
      txn(1, 3'd3, 4'd2, 16'd2345, 16'd0, 0, 0, 1'b0, 1'b1, 1);
      wait_idle();
      set_req(0, 3'd3, 4'd1, 16'd1234, 16'd0, 0);
      await_grant(0);
      wait_core(1'b1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_core_rst_n", 32'(core_rst_n), 32'd0);
      chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      chk("abort_rsp_locked", 32'(rsp_locked), 32'd0);
      chk("abort_rsp_balance", rsp_balance, 32'd0);
      @(posedge clk);
      #1;
      // Reset cleared the fail counters, so account 2 is served
      txn(1, 3'd3, 4'd2, 16'd2345, 16'd0, 0, 3000, 1'b1, 1'b0, 7);

      // Withdraw, over-withdraw, PIN change, query with the new PIN
      txn(3, 3'd4, 4'd1, 16'd1234, 16'd0, 300, 700, 1'b1, 1'b0, 7);
      txn(3, 3'd4, 4'd1, 16'd1234, 16'd0, 800, 700, 1'b0, 1'b0, 7);
      txn(3, 3'd6, 4'd1, 16'd1234, 16'd4321, 0, 700, 1'b1, 1'b0, 7);
      txn(3, 3'd3, 4'd1, 16'd4321, 16'd0, 0, 700, 1'b1, 1'b0, 7);
      wait_idle();
      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, outstanding=%0d", sb.size());
      $fatal(1, "watchdog");
   end

endmodule
